data_mem_arbiter: RTL and testbench

- Shares the single-port 16-bit data memory (4K words, 1-cycle registered read) between the processor core and a debug/loader port.
- Core normally has priority.
- Bounded-starvation counter guarantees debug progress; debug may lock the memory for burst loads.
- Sits between control/datapath and the block memory; drives its clka-domain address/we/din and routes douta back to the winning requester.

---
 rtl/data_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares one single-port data memory between the processor core and a
// debug/loader port. The core normally wins. A run counter forces a debug
// slot after MAX_CORE_RUN consecutive core grants while debug waits. Debug
// may lock the memory for burst loads. Read data comes back one cycle after
// the grant and is steered to whichever side issued the read.
module data_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int MAX_CORE_RUN = 4
) (
    input  logic              CLK,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_owns,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int              CNT_W     = $clog2(MAX_CORE_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_CORE_RUN);

    typedef enum logic {
        SHARED = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    lock_state_t      state;
    logic [CNT_W-1:0] run_cnt;
    logic [1:0]       rd_tag;   // {core_rd, dbg_rd} of the previous cycle's grant

    // Pick this cycle's winner: lock owner first, then starvation guard, then core.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!reset) begin
            if (dbg_owns) begin
                dbg_gnt = dbg_req;
            end else if (core_req && dbg_req && (run_cnt == RUN_LIMIT)) begin
                dbg_gnt = 1'b1;
            end else if (core_req) begin
                core_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    assign core_stall = core_req & ~core_gnt;

    // Drive the memory from the winner; park everything at zero when idle.
    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_din  = '0;
        if (core_gnt) begin
            mem_addr = core_addr;
            mem_we   = core_we;
            mem_din  = core_wdata;
        end else if (dbg_gnt) begin
            mem_addr = dbg_addr;
            mem_we   = dbg_we;
            mem_din  = dbg_wdata;
        end
    end

    // Count consecutive core grants while debug is waiting, saturating at the limit.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            run_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            run_cnt <= '0;
        end else if (core_gnt && (run_cnt != RUN_LIMIT)) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    // Lock FSM: a granted locked debug access takes ownership, dropping dbg_lock releases it.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= SHARED;
            dbg_owns <= 1'b0;
        end else begin
            case (state)
                SHARED: begin
                    if (dbg_gnt && dbg_lock) begin
                        state    <= LOCKED;
                        dbg_owns <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!dbg_lock) begin
                        state    <= SHARED;
                        dbg_owns <= 1'b0;
                    end
                end
                default: begin
                    state    <= SHARED;
                    dbg_owns <= 1'b0;
                end
            endcase
        end
    end

    // Remember which side issued a read so the returning data can be steered.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_tag <= 2'b00;
        end else begin
            rd_tag <= {core_gnt & ~core_we, dbg_gnt & ~dbg_we};
        end
    end

    // A read whose data would return during reset is dropped, so gate with reset.
    assign core_rvalid = rd_tag[1] & ~reset;
    assign dbg_rvalid  = rd_tag[0] & ~reset;
    assign core_rdata  = core_rvalid ? mem_dout : '0;
    assign dbg_rdata   = dbg_rvalid  ? mem_dout : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a write-first, 1-cycle-read memory model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_data_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    logic              CLK;
    logic              reset;
    logic              core_req, core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt, core_stall, core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              dbg_req, dbg_we, dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt, dbg_owns, dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    int checks = 0;
    int errors = 0;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CORE_RUN(4)) dut (
        .CLK(CLK), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
        .dbg_owns(dbg_owns), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Write-first single-port memory model
    logic [DATA_W-1:0] mem [4096];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem_dout = '0;
    end
    always @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem_we ? mem_din : mem[mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        core_req = 1; core_we = 1; core_addr = 12'h001; core_wdata = 16'hFFFF;
        dbg_req = 1; dbg_we = 1; dbg_addr = 12'h002; dbg_wdata = 16'hEEEE; dbg_lock = 1;
        tick(); tick();
        @(negedge CLK);
        checks++; if (core_gnt !== 1'b0) begin errors++; $display("FAIL reset_core_gnt: got %b expected 0", core_gnt); end
        checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL reset_dbg_gnt: got %b expected 0", dbg_gnt); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (dbg_owns !== 1'b0) begin errors++; $display("FAIL reset_dbg_owns: got %b expected 0", dbg_owns); end
        checks++; if ({core_rvalid, dbg_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {core_rvalid, dbg_rvalid}); end
        checks++; if ({core_rdata, dbg_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {core_rdata, dbg_rdata}); end
        tick();
        reset = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_core_only();
        core_req = 1; core_we = 1; core_addr = 12'h005; core_wdata = 16'h1234;
        @(negedge CLK);
        checks++; if (core_gnt !== 1'b1 || core_stall !== 1'b0) begin errors++; $display("FAIL core_wr_gnt: got gnt=%b stall=%b expected 1/0", core_gnt, core_stall); end
        checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 12'h005, 16'h1234}) begin errors++; $display("FAIL core_wr_mem: got we=%b addr=%h din=%h expected 1/005/1234", mem_we, mem_addr, mem_din); end
        tick();
        core_we = 0; core_wdata = '0;
        @(negedge CLK);
        checks++; if (core_gnt !== 1'b1 || core_stall !== 1'b0) begin errors++; $display("FAIL core_rd_gnt: got gnt=%b stall=%b expected 1/0", core_gnt, core_stall); end
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL core_wr_no_rvalid: got %b expected 0", core_rvalid); end
        tick();
        idle_inputs();
        @(negedge CLK);
        checks++; if (core_rvalid !== 1'b1 || core_rdata !== 16'h1234) begin errors++; $display("FAIL core_rd_data: got v=%b d=%h expected 1/1234", core_rvalid, core_rdata); end
        checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 16'h0) begin errors++; $display("FAIL core_rd_other: got v=%b d=%h expected 0/0000", dbg_rvalid, dbg_rdata); end
        tick();
    endtask

    task automatic test_simultaneous();
        core_req = 1; core_addr = 12'h005;
        dbg_req = 1; dbg_addr = 12'h006;
        @(negedge CLK);
        checks++; if ({core_gnt, dbg_gnt, core_stall} !== 3'b100) begin errors++; $display("FAIL simul_core_wins: got gnt c/d/stall=%b expected 100", {core_gnt, dbg_gnt, core_stall}); end
        tick();
        core_req = 0;
        @(negedge CLK);
        checks++; if ({core_gnt, dbg_gnt} !== 2'b01) begin errors++; $display("FAIL simul_dbg_next: got c/d=%b expected 01", {core_gnt, dbg_gnt}); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_contention();
        logic exp_d;
        core_req = 1; core_addr = 12'h010;
        dbg_req = 1; dbg_addr = 12'h020;
        for (int i = 0; i < 12; i++) begin
            exp_d = ((i % 5) == 4);
            @(negedge CLK);
            checks++; if ({core_gnt, dbg_gnt, core_stall} !== {~exp_d, exp_d, exp_d}) begin errors++; $display("FAIL contention_cycle%0d: got c/d/stall=%b expected %b", i, {core_gnt, dbg_gnt, core_stall}, {~exp_d, exp_d, exp_d}); end
            if (i > 0) begin
                checks++; if ({core_rvalid, dbg_rvalid} !== {((i - 1) % 5) != 4, ((i - 1) % 5) == 4}) begin errors++; $display("FAIL contention_rvalid%0d: got %b", i, {core_rvalid, dbg_rvalid}); end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock_burst();
        int first;
        // dbg_lock without dbg_req takes no lock
        dbg_lock = 1;
        tick();
        @(negedge CLK);
        checks++; if (dbg_owns !== 1'b0) begin errors++; $display("FAIL lock_needs_grant: got %b expected 0", dbg_owns); end
        tick();
        // Core keeps reading 0x102; debug loads 0x100..0x103 under lock
        core_req = 1; core_we = 0; core_addr = 12'h102;
        dbg_req = 1; dbg_we = 1; dbg_addr = 12'h100; dbg_wdata = 16'hA000;
        first = -1;
        for (int c = 0; c < 10 && first < 0; c++) begin
            @(negedge CLK);
            if (dbg_gnt === 1'b1) first = c;
            else tick();
        end
        checks++; if (first != 4) begin errors++; $display("FAIL lock_first_grant_cycle: got %0d expected 4", first); end
        checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 12'h100, 16'hA000}) begin errors++; $display("FAIL lock_wr0_mem: got %b/%h/%h expected 1/100/a000", mem_we, mem_addr, mem_din); end
        checks++; if (dbg_owns !== 1'b0) begin errors++; $display("FAIL lock_owns_before: got %b expected 0", dbg_owns); end
        tick();
        for (int k = 1; k < 4; k++) begin
            dbg_addr = 12'h100 + 12'(k); dbg_wdata = 16'hA000 + 16'(k);
            if (k == 3) dbg_lock = 0;   // release in the same cycle as the last write
            @(negedge CLK);
            checks++; if ({dbg_owns, dbg_gnt, core_gnt, core_stall} !== 4'b1101) begin errors++; $display("FAIL lock_wr%0d_gnt: got owns/d/c/stall=%b expected 1101", k, {dbg_owns, dbg_gnt, core_gnt, core_stall}); end
            checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 12'h100 + 12'(k), 16'hA000 + 16'(k)}) begin errors++; $display("FAIL lock_wr%0d_mem: got %b/%h/%h", k, mem_we, mem_addr, mem_din); end
            tick();
            if (k == 1) begin
                // Locked with no debug request: nobody is granted, core stalls
                dbg_req = 0;
                @(negedge CLK);
                checks++; if ({dbg_owns, dbg_gnt, core_gnt, core_stall, mem_we} !== 5'b10010) begin errors++; $display("FAIL lock_gap: got owns/d/c/stall/we=%b expected 10010", {dbg_owns, dbg_gnt, core_gnt, core_stall, mem_we}); end
                tick();
                dbg_req = 1;
            end
        end
        dbg_req = 0; dbg_we = 0;
        @(negedge CLK);
        checks++; if ({dbg_owns, core_gnt, core_stall} !== 3'b010) begin errors++; $display("FAIL lock_release_core: got owns/c/stall=%b expected 010", {dbg_owns, core_gnt, core_stall}); end
        tick();
        idle_inputs();
        @(negedge CLK);
        checks++; if (core_rvalid !== 1'b1 || core_rdata !== 16'hA002) begin errors++; $display("FAIL lock_readback: got v=%b d=%h expected 1/a002", core_rvalid, core_rdata); end
        tick();
    endtask

    task automatic test_read_pipeline();
        dbg_req = 1; dbg_addr = 12'h005;
        @(negedge CLK);
        checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL pipe_d0_gnt: got %b expected 1", dbg_gnt); end
        tick();
        dbg_req = 0; core_req = 1; core_addr = 12'h100;
        @(negedge CLK);
        checks++; if ({dbg_rvalid, dbg_rdata, core_rvalid, core_rdata} !== {1'b1, 16'h1234, 1'b0, 16'h0}) begin errors++; $display("FAIL pipe_ret0: got d=%b/%h c=%b/%h expected d=1/1234 c=0/0000", dbg_rvalid, dbg_rdata, core_rvalid, core_rdata); end
        tick();
        core_req = 0; dbg_req = 1; dbg_addr = 12'h101;
        @(negedge CLK);
        checks++; if ({core_rvalid, core_rdata, dbg_rvalid, dbg_rdata} !== {1'b1, 16'hA000, 1'b0, 16'h0}) begin errors++; $display("FAIL pipe_ret1: got c=%b/%h d=%b/%h expected c=1/a000 d=0/0000", core_rvalid, core_rdata, dbg_rvalid, dbg_rdata); end
        tick();
        idle_inputs();
        @(negedge CLK);
        checks++; if ({dbg_rvalid, dbg_rdata, core_rvalid, core_rdata} !== {1'b1, 16'hA001, 1'b0, 16'h0}) begin errors++; $display("FAIL pipe_ret2: got d=%b/%h c=%b/%h expected d=1/a001 c=0/0000", dbg_rvalid, dbg_rdata, core_rvalid, core_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic exp_d;
        // Phase 1: reset while locked with a read outstanding
        dbg_req = 1; dbg_lock = 1; dbg_addr = 12'h005;
        tick();
        core_req = 1; core_addr = 12'h100; dbg_addr = 12'h101;
        @(negedge CLK);
        checks++; if ({dbg_owns, dbg_gnt, core_stall} !== 3'b111) begin errors++; $display("FAIL rmid_locked: got owns/d/stall=%b expected 111", {dbg_owns, dbg_gnt, core_stall}); end
        tick();
        reset = 1;
        @(negedge CLK);
        checks++; if ({core_gnt, dbg_gnt, mem_we} !== 3'b000) begin errors++; $display("FAIL rmid_no_grant: got c/d/we=%b expected 000", {core_gnt, dbg_gnt, mem_we}); end
        checks++; if ({dbg_rvalid, dbg_rdata} !== 17'h0) begin errors++; $display("FAIL rmid_pending_dropped: got v=%b d=%h expected 0/0000", dbg_rvalid, dbg_rdata); end
        tick();
        reset = 0;
        idle_inputs();
        @(negedge CLK);
        checks++; if ({dbg_owns, core_rvalid, dbg_rvalid} !== 3'b000) begin errors++; $display("FAIL rmid_after: got owns/cv/dv=%b expected 000", {dbg_owns, core_rvalid, dbg_rvalid}); end
        tick();
        // Phase 2: run_cnt built up to 2, then reset; the pattern restarts from 0
        core_req = 1; core_addr = 12'h010; dbg_req = 1; dbg_addr = 12'h020;
        tick(); tick();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            exp_d = (i == 4);
            @(negedge CLK);
            checks++; if ({core_gnt, dbg_gnt} !== {~exp_d, exp_d}) begin errors++; $display("FAIL rmid_runcnt%0d: got c/d=%b expected %b", i, {core_gnt, dbg_gnt}, {~exp_d, exp_d}); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        tick();
        test_reset();
        test_core_only();
        test_simultaneous();
        test_contention();
        test_lock_burst();
        test_read_pipeline();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
